// File: rtl/mem_inject_arbiter.sv
// mem_inject_arbiter
//   Round-robin arbiter that shares one network local injection port among
//   NUM_REQ core requesters. A granted request is latched and sent as one
//   flit (narrow access, or any read) or WIDE_WIDTH/FLIT_SIZE flits (wide
//   write with SRF mode enabled). The grant is held until the last flit is
//   accepted. The requester is then acked for one cycle.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   srf_enable        SRF mode; enables multi-flit wide writes
//   req_valid/read/wide/addr/data   per-requester request (packed slices)
//   req_ack           one-cycle pulse when a requester's packet is injected
//   flit_valid/ready  handshake with the router local port
//   flit_addr/data/src/idx/read/wide/last   flit fields (zero when idle)
//   busy              arbiter is not in IDLE
module mem_inject_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int WIDE_WIDTH = 256,
  parameter int FLIT_SIZE  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          srf_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_wide,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDE_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          flit_valid,
  input  logic                          flit_ready,
  output logic [ADDR_WIDTH-1:0]         flit_addr,
  output logic [FLIT_SIZE-1:0]          flit_data,
  output logic [$clog2(NUM_REQ)-1:0]    flit_src,
  output logic [1:0]                    flit_idx,
  output logic                          flit_read,
  output logic                          flit_wide,
  output logic                          flit_last,
  output logic                          busy
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int FLITS = WIDE_WIDTH / FLIT_SIZE;
  localparam logic [1:0] LAST_WIDE = 2'(FLITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

  state_t                 state_q, state_d;
  logic [SRC_W-1:0]       rr_ptr_q;
  logic [SRC_W-1:0]       src_q;
  logic [SRC_W-1:0]       grant_idx;
  logic                   grant_found;
  logic [1:0]             idx_q;
  logic                   read_q;
  logic                   wide_q;   // wide AND srf_enable, as seen at grant
  logic                   multi_q;  // packet is a multi-flit wide write
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [WIDE_WIDTH-1:0]  data_q;
  logic                   is_last;

  assign is_last = (idx_q == (multi_q ? LAST_WIDE : 2'd0));

  // Search starts one past the last served requester, so it has lowest
  // priority next time.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[(32'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= SRC_W'(NUM_REQ - 1);
      src_q    <= '0;
      idx_q    <= '0;
      read_q   <= 1'b0;
      wide_q   <= 1'b0;
      multi_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            src_q   <= grant_idx;
            read_q  <= req_read[grant_idx];
            wide_q  <= req_wide[grant_idx] & srf_enable;
            multi_q <= req_wide[grant_idx] & ~req_read[grant_idx] & srf_enable;
            addr_q  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            data_q  <= req_data[grant_idx*WIDE_WIDTH +: WIDE_WIDTH];
            idx_q   <= '0;
          end
        end
        SEND: begin
          if (flit_ready && !is_last) idx_q <= idx_q + 2'd1;
        end
        ACK: rr_ptr_q <= src_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ack    = '0;
    flit_valid = 1'b0;
    flit_addr  = '0;
    flit_data  = '0;
    flit_src   = '0;
    flit_idx   = '0;
    flit_read  = 1'b0;
    flit_wide  = 1'b0;
    flit_last  = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_found) state_d = SEND;
      end
      SEND: begin
        flit_valid = 1'b1;
        flit_addr  = addr_q + (ADDR_WIDTH'(idx_q) << 3);
        flit_data  = data_q[FLIT_SIZE*idx_q +: FLIT_SIZE];
        flit_src   = src_q;
        flit_idx   = idx_q;
        flit_read  = read_q;
        flit_wide  = wide_q;
        flit_last  = is_last;
        if (flit_ready && is_last) state_d = ACK;
      end
      ACK: begin
        req_ack[src_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
